// File: rtl/mul_result_packer_if.sv
// Word-in / line-out bus of the multiplier result packer.
// The slave modport is the packer; the master modport is the AFU side.
interface mul_result_packer_if #(
    parameter int DATA_LEN  = 32,
    parameter int LINE_BITS = 512,
    parameter int IDX_W     = 16
);
    localparam int WORDS_PER_LINE = LINE_BITS / DATA_LEN;
    localparam int CNT_W          = $clog2(WORDS_PER_LINE) + 1;

    logic                 in_valid;
    logic [DATA_LEN-1:0]  in_data;
    logic                 in_last;
    logic                 in_ready;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [LINE_BITS-1:0] out_data;
    logic [CNT_W-1:0]     out_words;
    logic [IDX_W-1:0]     out_line_idx;
    logic                 out_last;

    modport master (
        output in_valid, in_data, in_last, flush, out_ready,
        input  in_ready, out_valid, out_data, out_words, out_line_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, flush, out_ready,
        output in_ready, out_valid, out_data, out_words, out_line_idx, out_last
    );
endinterface

// File: rtl/mul_result_packer.sv
// Packs DATA_LEN-bit multiplier results into cache lines for the c1 write path,
// with a 2-entry sealed-line FIFO to absorb write backpressure.
module mul_result_packer #(
    parameter int DATA_LEN  = 32,
    parameter int LINE_BITS = 512,
    parameter int IDX_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    mul_result_packer_if.slave  bus,
    output logic                busy
);
    localparam int WORDS_PER_LINE = LINE_BITS / DATA_LEN;
    localparam int SLOT_W         = $clog2(WORDS_PER_LINE);
    localparam int CNT_W          = SLOT_W + 1;

    logic [SLOT_W-1:0]    fill_cnt;
    logic [LINE_BITS-1:0] fill_line;
    logic [1:0]           seal_cnt;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic                 flush_pending;
    logic [IDX_W-1:0]     line_idx;

    logic [LINE_BITS-1:0] fifo_data  [2];
    logic [CNT_W-1:0]     fifo_words [2];
    logic [IDX_W-1:0]     fifo_idx   [2];
    logic                 fifo_last  [2];

    logic                 accept;
    logic                 pop;
    logic                 do_flush;
    logic                 seal;
    logic                 seal_last;
    logic [CNT_W-1:0]     new_cnt;
    logic [LINE_BITS-1:0] line_next;

    assign bus.in_ready     = (seal_cnt != 2'd2);
    assign bus.out_valid    = (seal_cnt != 2'd0);
    assign bus.out_data     = fifo_data[rd_ptr];
    assign bus.out_words    = fifo_words[rd_ptr];
    assign bus.out_line_idx = fifo_idx[rd_ptr];
    assign bus.out_last     = fifo_last[rd_ptr];
    assign busy             = (fill_cnt != '0) || (seal_cnt != 2'd0) || flush_pending;

    always_comb begin
        accept   = bus.in_valid && bus.in_ready;
        pop      = bus.out_valid && bus.out_ready;
        do_flush = bus.flush || flush_pending;
        new_cnt  = CNT_W'(fill_cnt) + CNT_W'(accept);
        line_next = fill_line;
        if (accept) begin
            line_next[int'(fill_cnt)*DATA_LEN +: DATA_LEN] = bus.in_data;
        end
        // Flush and the accepting word share one seal, so the word lands in the flushed line.
        seal = bus.in_ready &&
               ((accept && ((new_cnt == CNT_W'(WORDS_PER_LINE)) || bus.in_last)) ||
                (do_flush && (new_cnt != '0)));
        seal_last = (accept && bus.in_last) || do_flush;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            fill_cnt      <= '0;
            fill_line     <= '0;
            seal_cnt      <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            flush_pending <= 1'b0;
            line_idx      <= '0;
        end else begin
            if (seal) begin
                wr_ptr    <= ~wr_ptr;
                fill_cnt  <= '0;
                fill_line <= '0;
                line_idx  <= line_idx + IDX_W'(1);
            end else if (accept) begin
                fill_cnt  <= fill_cnt + SLOT_W'(1);
                fill_line <= line_next;
            end

            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({seal, pop})
                2'b10:   seal_cnt <= seal_cnt + 2'd1;
                2'b01:   seal_cnt <= seal_cnt - 2'd1;
                default: seal_cnt <= seal_cnt;
            endcase

            // A flush that meets a full FIFO waits for the first free slot.
            if (bus.in_ready) begin
                flush_pending <= 1'b0;
            end else if (bus.flush && (fill_cnt != '0)) begin
                flush_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!(reset || clear) && seal) begin
            fifo_data[wr_ptr]  <= line_next;
            fifo_words[wr_ptr] <= new_cnt;
            fifo_idx[wr_ptr]   <= line_idx;
            fifo_last[wr_ptr]  <= seal_last;
        end
    end

    in_valid_while_full: assert property (
        @(posedge clk) disable iff (reset || clear) !(bus.in_valid && !bus.in_ready)
    ) else $error("mul_result_packer: in_valid asserted while in_ready=0, word dropped");
endmodule

// File: tb/tb_mul_result_packer.sv
// Bench for mul_result_packer: directed table, corner sequences and random traffic,
// all checked against a queue-based line model; a second instance has IDX_W=2.
module tb_mul_result_packer;
    localparam int DL  = 32;
    localparam int LB  = 512;
    localparam int IW  = 16;
    localparam int WPL = LB / DL;

    logic clk = 1'b0;
    logic reset;
    logic clear;
    logic busy;
    logic busy2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_result_packer_if #(.DATA_LEN(DL), .LINE_BITS(LB), .IDX_W(IW)) bus ();
    mul_result_packer_if #(.DATA_LEN(DL), .LINE_BITS(LB), .IDX_W(2))  bus2 ();

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_data   = bus.in_data;
    assign bus2.in_last   = bus.in_last;
    assign bus2.flush     = bus.flush;
    assign bus2.out_ready = bus.out_ready;

    mul_result_packer #(.DATA_LEN(DL), .LINE_BITS(LB), .IDX_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus),
        .busy  (busy)
    );

    mul_result_packer #(.DATA_LEN(DL), .LINE_BITS(LB), .IDX_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus2),
        .busy  (busy2)
    );

    // Reference model: words waiting in the fill line, and sealed lines not yet taken.
    typedef struct {
        logic [LB-1:0] data;
        int            words;
        int            idx;
        bit            last;
    } line_t;

    line_t       sealed_q[$];
    logic [31:0] fill_q[$];
    int          m_idx  = 0;
    bit          m_pend = 1'b0;

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_check();
        bit ov;
        ov = (sealed_q.size() > 0);
        chk("out_valid", bus.out_valid, ov);
        chk("in_ready", bus.in_ready, sealed_q.size() < 2);
        chk("busy", busy, (fill_q.size() > 0) || ov || m_pend);
        chk("out_valid_idx2", bus2.out_valid, ov);
        chk("busy_idx2", busy2, (fill_q.size() > 0) || ov || m_pend);
        if (ov) begin
            chk("out_data", bus.out_data, sealed_q[0].data);
            chk("out_words", bus.out_words, sealed_q[0].words);
            chk("out_line_idx", bus.out_line_idx, sealed_q[0].idx % 65536);
            chk("out_last", bus.out_last, sealed_q[0].last);
            chk("out_line_idx_w2", bus2.out_line_idx, sealed_q[0].idx % 4);
        end
    endtask

    task automatic model_step();
        bit            rdy;
        bit            acc;
        bit            fl;
        bit            do_seal;
        line_t         ln;
        if (reset || clear) begin
            sealed_q.delete();
            fill_q.delete();
            m_idx  = 0;
            m_pend = 1'b0;
            return;
        end
        rdy = (sealed_q.size() < 2);
        acc = bus.in_valid && rdy;
        if (acc) fill_q.push_back(bus.in_data);
        fl = bus.flush || m_pend;
        do_seal = rdy && ((acc && (fill_q.size() == WPL || bus.in_last)) ||
                          (fl && fill_q.size() > 0));
        if (sealed_q.size() > 0 && bus.out_ready) void'(sealed_q.pop_front());
        if (do_seal) begin
            ln.data = '0;
            foreach (fill_q[i]) ln.data[i*DL +: DL] = fill_q[i];
            ln.words = fill_q.size();
            ln.idx   = m_idx;
            ln.last  = (acc && bus.in_last) || fl;
            sealed_q.push_back(ln);
            fill_q.delete();
            m_idx++;
        end
        if (rdy) m_pend = 1'b0;
        else if (bus.flush && fill_q.size() > 0) m_pend = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input bit l, input bit f,
                         input bit r, input bit c);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.flush     = f;
        bus.out_ready = r;
        clear         = c;
        tick();
    endtask

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          l;
        bit          f;
        bit          r;
        bit          e_valid;
        bit          e_ready;
        bit          e_busy;
        int          e_words;
        int          e_idx;
        bit          e_last;
    } vec_t;

    vec_t tbl[9];
    int   exp_idx2[5];

    initial begin
        tbl[0] = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
        tbl[1] = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
        tbl[2] = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
        tbl[3] = '{1'b1, 32'hD,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
        tbl[4] = '{1'b1, 32'hE,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5, 0, 1'b1};
        tbl[5] = '{1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
        tbl[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 1'b1};
        tbl[7] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
        tbl[8] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
        exp_idx2 = '{0, 1, 2, 3, 0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        clear         = 1'b0;
        reset         = 1'b1;
        @(posedge clk);
        #1;
        tick();
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_in_ready", bus.in_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        reset = 1'b0;

        // Full line of 1..16 with the consumer ready.
        for (int i = 1; i <= WPL; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == WPL - 1) chk("full_not_yet_valid", bus.out_valid, 1'b0);
        end
        chk("full_valid", bus.out_valid, 1'b1);
        chk("full_words", bus.out_words, 16);
        chk("full_last", bus.out_last, 1'b0);
        chk("full_idx", bus.out_line_idx, 0);
        chk("full_word0", bus.out_data[31:0], 1);
        chk("full_word15", bus.out_data[511:480], 16);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Partial line sealed by in_last, then a flushed one-word line.
        for (int i = 0; i < 9; i++) begin
            logic [LB-1:0] unused_mask;
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].f, tbl[i].r, 1'b0);
            chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].e_ready);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_valid) begin
                unused_mask = {LB{1'b1}} << (tbl[i].e_words * DL);
                chk($sformatf("tbl%0d_words", i), bus.out_words, tbl[i].e_words);
                chk($sformatf("tbl%0d_idx", i), bus.out_line_idx, tbl[i].e_idx);
                chk($sformatf("tbl%0d_last", i), bus.out_last, tbl[i].e_last);
                chk($sformatf("tbl%0d_unused_zero", i), bus.out_data & unused_mask, '0);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure: only 32 words fit before in_ready drops.
        begin
            int acc = 0;
            for (int i = 0; i < 40; i++) begin
                if (sealed_q.size() < 2) begin
                    drive(1'b1, 32'(100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
                    acc++;
                end else begin
                    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
                end
            end
            chk("bp_accepted", acc, 32);
            chk("bp_in_ready_low", bus.in_ready, 1'b0);
            chk("bp_head_idx0", bus.out_line_idx, 0);
            drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("bp_in_ready_back", bus.in_ready, 1'b1);
            chk("bp_head_idx1", bus.out_line_idx, 1);
            drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("bp_drained", bus.out_valid, 1'b0);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // One line pending, then pop and seal on the same edge.
        for (int i = 0; i < WPL; i++) drive(1'b1, 32'(300 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WPL; i++) begin
            drive(1'b1, 32'(400 + i), 1'b0, 1'b0, (i == WPL - 1), 1'b0);
            chk("pp_in_ready", bus.in_ready, 1'b1);
        end
        chk("pp_valid", bus.out_valid, 1'b1);
        chk("pp_head_idx", bus.out_line_idx, 1);
        chk("pp_head_word0", bus.out_data[31:0], 400);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pp_drained", bus.out_valid, 1'b0);

        // Clear mid-fill, with a word offered on the clear cycle.
        for (int i = 0; i < 7; i++) drive(1'b1, 32'(500 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_busy", busy, 1'b0);
        chk("clr_out_valid", bus.out_valid, 1'b0);
        chk("clr_in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < WPL; i++) drive(1'b1, 32'(600 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_idx", bus.out_line_idx, 0);
        chk("clr_word0", bus.out_data[31:0], 600);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Narrow index wraps after four lines.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < WPL; i++) drive(1'b1, 32'(k * 16 + i), 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("wrap_idx_line%0d", k), bus2.out_line_idx, exp_idx2[k]);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("empty_flush_valid", bus.out_valid, 1'b0);
        chk("empty_flush_busy", busy, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit v;
            v = ($urandom_range(0, 3) != 0) && (sealed_q.size() < 2);
            drive(v, $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 199) == 0));
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_result_packer.md
Name: mul_result_packer

Overview:
- Downstream stage of the pipelined multiplier inside the AFU.
- Collects per-operation DATA_LEN-bit results into 512-bit cache lines and presents each sealed line to the AFU c1 write path, together with a line index and a valid-word count.
- Lets the AFU write batches of results with one CCI-P write per full line, instead of one write per result.
- Provides 2-entry line buffering so write-path backpressure does not drop results.

Parameters:
- DATA_LEN, 32, result word width; must divide LINE_BITS.
- LINE_BITS, 512, cache-line width; fixed to t_ccip_clData width.
- WORDS_PER_LINE, LINE_BITS/DATA_LEN (16), derived; not overridable.
- IDX_W, 16, width of the line index counter.

Ports:
- clk  in  1  Clock.
- reset  in  1  Reset; synchronous, active-high.
- clear  in  1  Soft clear pulse, driven from the AFU reset CSR path; same effect as reset.
- in_valid  in  1  Result word present this cycle.
- in_data  in  DATA_LEN  Result word.
- in_last  in  1  Qualifies in_valid; this word ends the batch, so the line is sealed even if partial.
- in_ready  out  1  Packer can accept a word this cycle.
- flush  in  1  Seals the partial fill line without supplying a word.
- out_valid  out  1  Head sealed line available.
- out_ready  in  1  Consumer takes the head line this cycle.
- out_data  out  LINE_BITS  Packed line; word i at [i*DATA_LEN +: DATA_LEN]; unused words are 0.
- out_words  out  $clog2(WORDS_PER_LINE)+1  Number of valid words in the line (1..16).
- out_line_idx  out  IDX_W  Sequence number of the line, added by the AFU to output_addr.
- out_last  out  1  Line was sealed by in_last or flush.
- busy  out  1  Fill line non-empty or any sealed line pending.

Behaviour:
- Storage:
  - One fill register with word counter fill_cnt (0..WORDS_PER_LINE-1).
  - 2-entry sealed-line FIFO with count seal_cnt (0..2), plus a per-entry words/idx/last sideband.
- Reset or clear (clear takes priority over every other input):
  - Next cycle: fill_cnt=0, seal_cnt=0, fill register zeroed, line index=0.
  - Outputs: out_valid=0, busy=0, in_ready=1.
  - In-flight data is discarded. This applies mid-fill and with lines pending.
- Handshakes:
  - in_ready = (seal_cnt < 2), registered-state only, with no combinational path from out_ready.
  - A word is accepted when in_valid && in_ready.
  - in_valid while in_ready=0 is a protocol error: the word is dropped and a simulation $error fires.
  - out_valid = (seal_cnt > 0). The head is popped on out_valid && out_ready.
  - out_data, out_words, out_line_idx and out_last are stable while out_valid && !out_ready.
- Accepting a word: it is written to slot fill_cnt and fill_cnt increments.
- Sealing:
  - A line is sealed when an accepted word makes the count WORDS_PER_LINE (out_last=0), or when an accepted word carries in_last (out_last=1, even if the line is full).
  - The sealed line, including the accepting word, is pushed to the FIFO on the same edge.
  - fill_cnt returns to 0, the fill register is zeroed, and the line index increments.
- flush:
  - If fill_cnt>0 and seal_cnt<2, the partial line is sealed with out_last=1.
  - If fill_cnt==0 it is a no-op.
  - If the FIFO is full, flush is held pending internally and executes on the first cycle seal_cnt<2.
  - flush in the same cycle as an accepted in_valid word: the word is included, and only one line is sealed.
- Latency:
  - The sealing word is accepted at edge N; out_valid=1 after edge N when the FIFO was empty.
  - If the FIFO was not empty, the line follows the pending lines in order.
- Simultaneous push and pop: seal_cnt is unchanged, and in_ready stays 1 when seal_cnt was 1.
- seal_cnt goes to 2 after edge N: in_ready=0 from that cycle until a pop.
- Line index wraps modulo 2^IDX_W without a flag.
- out_words is the fill_cnt value at sealing time (including the sealing word).
- busy = (fill_cnt != 0) || (seal_cnt != 0) || flush_pending.

Test Plan:
- 16 words 1..16 with out_ready=1 → one line: out_words=16, out_last=0, idx=0, word0=1, word15=16, out_valid one cycle after the 16th accept.
- 5 words 0xA..0xE, last word with in_last → out_words=5, out_last=1, bits [511:160]=0; a following word lands in a line with idx=1.
- out_ready=0, stream 40 words → in_ready falls after the 32nd accept; the 33rd word is not sent. Raise out_ready → lines idx 0,1 delivered in order, and in_ready returns the cycle after the first pop.
- seal_cnt=1, with pop and seal of a new line on the same edge → seal_cnt stays 1, in_ready never drops, FIFO order preserved.
- 7 words accepted then clear pulse → next cycle busy=0, out_valid=0; a new 16-word batch yields idx=0 with no stale words.
- IDX_W=2, seal 5 full lines → idx sequence 0,1,2,3,0. flush with fill_cnt=0 → no line.
